// File: rtl/spike_aer_logger_pkg.sv
// Shared definitions for the spike AER logger.
// Event word layout, LSB first: spike mask, timestamp, wrap flag in the MSB.
package spike_aer_logger_pkg;

   localparam int AER_TS_W     = 16;
   localparam int DROP_W       = 16;
   localparam int AER_MASK_LSB = 0;

   typedef logic [DROP_W-1:0] drop_cnt_t;

   function automatic int aer_ts_lsb(input int n_ch);
      return n_ch;
   endfunction

   function automatic int aer_wrap_bit(input int ts_w, input int n_ch);
      return ts_w + n_ch;
   endfunction

endpackage

// File: rtl/aer_sync_fifo.sv
// Synchronous FIFO with a first-word-fall-through head register.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             synchronous flush (priority over push/pop)
//   push, wdata     write request and data; push_ok reports acceptance
//   rd_valid/ready  head handshake, rd_data is the head word
//   level           total occupancy (storage + head register), 0..DEPTH
module aer_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   output logic                     push_ok,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             mem_empty;
   logic             mem_full;
   logic             full;
   logic             pop;
   logic             load;

   // A full FIFO still accepts a push when the head leaves on the same edge.
   // The head register refills from storage whenever it is empty or popped,
   // so a word written into empty storage becomes visible one edge later.
   always_comb begin
      mem_empty = (wr_ptr == rd_ptr);
      mem_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      full      = (level == LVL_W'(DEPTH));
      pop       = rd_valid && rd_ready;
      push_ok   = push && !mem_full && (!full || pop);
      load      = !mem_empty && (!rd_valid || pop);
   end

   always_ff @(posedge clk) begin
      if (push_ok && !clr) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         level    <= '0;
      end else if (clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         level    <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + ONE;
         end
         if (load) begin
            rd_ptr   <= rd_ptr + ONE;
            rd_valid <= 1'b1;
            rd_data  <= mem[rd_ptr[AW-1:0]];
         end else if (pop) begin
            rd_valid <= 1'b0;
         end
         case ({push_ok, pop})
            2'b10:   level <= level + ONE;
            2'b01:   level <= level - ONE;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/spike_aer_logger.sv
// Spike recorder: timestamps every non-empty spike cycle (and every timestamp
// wrap) as an address-event word and queues it for a valid/ready consumer.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   en              logging enable; timestamp frozen and spikes ignored when 0
//   clr             synchronous clear of timestamp, FIFO, drop count, overflow
//   spk_in          spike lines, bit i = neuron i
//   ev_valid/ready  output stream handshake, ev_data = {wrap, ts, mask}
//   fifo_level      queued words
//   drop_cnt        words lost to a full FIFO (saturating)
//   overflow        sticky, set on the first drop
module spike_aer_logger
   import spike_aer_logger_pkg::*;
#(
   parameter int N_CH  = 2,
   parameter int TS_W  = AER_TS_W,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    clr,
   input  logic [N_CH-1:0]         spk_in,
   output logic                    ev_valid,
   input  logic                    ev_ready,
   output logic [TS_W+N_CH:0]      ev_data,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [DROP_W-1:0]       drop_cnt,
   output logic                    overflow
);

   localparam int EV_W     = 1 + TS_W + N_CH;
   localparam int TS_LSB   = aer_ts_lsb(N_CH);
   localparam int WRAP_BIT = aer_wrap_bit(TS_W, N_CH);
   localparam logic [TS_W-1:0] TS_ONE   = {{(TS_W-1){1'b0}}, 1'b1};
   localparam drop_cnt_t       DROP_ONE = drop_cnt_t'(1);

   logic [TS_W-1:0] ts;
   logic            started;
   logic            wrap_cycle;
   logic            push_req;
   logic            push_ok;
   logic            drop;
   logic [EV_W-1:0] ev_word;

   // started distinguishes the very first ts==0 after reset/clear from a real
   // wrap, so each wrap is reported exactly once.
   always_comb begin
      wrap_cycle = en && started && (ts == '0);
      push_req   = !clr && en && ((spk_in != '0) || wrap_cycle);
      drop       = push_req && !push_ok;
      ev_word                         = '0;
      ev_word[WRAP_BIT]               = wrap_cycle;
      ev_word[TS_LSB +: TS_W]         = ts;
      ev_word[AER_MASK_LSB +: N_CH]   = spk_in;
   end

   // A clear restarts time from scratch, so started drops with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts       <= '0;
         started  <= 1'b0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         ts       <= '0;
         started  <= 1'b0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (en) begin
            ts      <= ts + TS_ONE;
            started <= 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + DROP_ONE;
            end
         end
      end
   end

   aer_sync_fifo #(
      .WIDTH (EV_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .push     (push_req),
      .wdata    (ev_word),
      .push_ok  (push_ok),
      .rd_valid (ev_valid),
      .rd_ready (ev_ready),
      .rd_data  (ev_data),
      .level    (fifo_level)
   );

endmodule

// File: tb/tb_spike_aer_logger.sv
module tb_spike_aer_logger;

   localparam int N_CH   = 2;
   localparam int TS_W   = 4;
   localparam int DEPTH  = 16;
   localparam int EV_W   = 1 + TS_W + N_CH;
   localparam int TS_MOD = 1 << TS_W;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   en = 1'b0;
   logic                   clr = 1'b0;
   logic                   ev_ready = 1'b0;
   logic [N_CH-1:0]        spk_in = '0;
   logic                   ev_valid;
   logic [EV_W-1:0]        ev_data;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [15:0]            drop_cnt;
   logic                   overflow;

   spike_aer_logger #(.N_CH(N_CH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .clr        (clr),
      .spk_in     (spk_in),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_data    (ev_data),
      .fifo_level (fifo_level),
      .drop_cnt   (drop_cnt),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: a queue of accepted words, each tagged with the edge
   // number at which it was accepted. A word is visible at the head once at
   // least one further edge has passed since its acceptance.
   typedef struct { int word; int pe; } ent_t;
   ent_t mq[$];
   int   exp_q[$];
   int   ts_m, drop_m, edge_n, pops;
   bit   started_m, ovf_m, hold_valid;
   logic [EV_W-1:0] hold_data;

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      ts_m = 0;
      started_m = 0;
      drop_m = 0;
      ovf_m = 0;
      hold_valid = 0;
   endtask

   task automatic step(input bit e, input bit c, input logic [N_CH-1:0] s, input bit r,
                       input bit arst = 0);
      bit vm, pop, wrap;
      int w, sz;
      @(negedge clk);
      vm = (mq.size() > 0) && (mq[0].pe < edge_n);
      chk("ev_valid", ev_valid, vm);
      chk("fifo_level", fifo_level, mq.size());
      chk("drop_cnt", drop_cnt, drop_m);
      chk("overflow", overflow, ovf_m);
      en = e; clr = c; spk_in = s; ev_ready = r;
      if (arst) begin
         #3;
         rst_n = 1'b0;
         #1;
         chk("rst_ev_valid", ev_valid, 0);
         chk("rst_ev_data", ev_data, 0);
         chk("rst_fifo_level", fifo_level, 0);
         chk("rst_drop_cnt", drop_cnt, 0);
         chk("rst_overflow", overflow, 0);
         rst_n = 1'b1;
         model_reset();
         vm = 0;
      end
      edge_n++;
      if (c) begin
         model_reset();
      end else begin
         sz  = mq.size();
         pop = vm && r;
         if (pop) void'(mq.pop_front());
         if (e) begin
            wrap = started_m && (ts_m == 0);
            if (s != 0 || wrap) begin
               w = (int'(wrap) << (TS_W + N_CH)) | (ts_m << N_CH) | int'(s);
               if (sz < DEPTH || pop) begin
                  mq.push_back('{word: w, pe: edge_n});
                  exp_q.push_back(w);
               end else begin
                  if (drop_m < 16'hFFFF) drop_m++;
                  ovf_m = 1;
               end
            end
            ts_m = (ts_m + 1) % TS_MOD;
            started_m = 1;
         end
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT hands over a word, and
   // checks that a stalled head holds still.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (hold_valid) begin
               chk("hold_valid", ev_valid, 1);
               chk("hold_data", ev_data, hold_data);
            end
            if (ev_valid && ev_ready && !clr) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_word actual=%0h expected=none", ev_data);
               end else begin
                  chk("ev_data", ev_data, exp_q.pop_front());
               end
               pops++;
            end
            hold_valid = ev_valid && !ev_ready && !clr;
            hold_data  = ev_data;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   int p0;

   initial begin
      edge_n = 0;
      pops = 0;
      model_reset();
      #22;
      chk("reset_ev_valid", ev_valid, 0);
      chk("reset_ev_data", ev_data, 0);
      chk("reset_fifo_level", fifo_level, 0);
      chk("reset_drop_cnt", drop_cnt, 0);
      chk("reset_overflow", overflow, 0);
      rst_n = 1'b1;

      // Single spike at ts=5, then a two-channel spike at ts=7.
      p0 = pops;
      for (int i = 0; i < 5; i++) step(1, 0, 2'b00, 1);
      step(1, 0, 2'b01, 1);
      @(posedge clk); #1;
      chk("lat_edge_k", ev_valid, 0);
      step(1, 0, 2'b00, 1);
      @(posedge clk); #1;
      chk("lat_edge_k1", ev_valid, 1);
      chk("single_word", ev_data, 7'b0_0101_01);
      step(1, 0, 2'b11, 1);
      @(posedge clk); #1;
      chk("one_cycle_valid", ev_valid, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 2'b00, 1);
      #3;
      chk("spike_word_count", pops - p0, 2);

      // Wrap markers at ts wrap, then a spike on a wrap cycle.
      step(1, 1, 2'b00, 1);
      p0 = pops;
      for (int i = 0; i < 42; i++) step(1, 0, 2'b00, 1);
      #3;
      chk("wrap_marker_count", pops - p0, 2);
      p0 = pops;
      for (int i = 0; i < 6; i++) step(1, 0, 2'b00, 1);
      step(1, 0, 2'b10, 1);
      @(posedge clk); #1;
      step(1, 0, 2'b00, 1);
      @(posedge clk); #1;
      chk("wrap_spike_word", ev_data, 7'b1_0000_10);
      for (int i = 0; i < 2; i++) step(1, 0, 2'b00, 1);
      #3;
      chk("wrap_spike_count", pops - p0, 1);

      // Overflow: 20 spikes into a stalled FIFO.
      step(1, 1, 2'b00, 0);
      for (int i = 0; i < 20; i++) step(1, 0, 2'b01, 0);
      @(posedge clk); #1;
      chk("ovf_level", fifo_level, 16);
      chk("ovf_drop_cnt", drop_cnt, 4);
      chk("ovf_flag", overflow, 1);
      step(1, 0, 2'b01, 1);
      @(posedge clk); #1;
      chk("full_pushpop_level", fifo_level, 16);
      chk("full_pushpop_drop", drop_cnt, 4);
      p0 = pops;
      for (int i = 0; i < 20; i++) step(0, 0, 2'b00, 1);
      #3;
      chk("drain_count", pops - p0, 16);

      // Random spike train with random backpressure and rare clears.
      for (int i = 0; i < 400; i++)
         step(($urandom % 10) != 0, ($urandom % 100) == 0,
              N_CH'($urandom), ($urandom % 2) == 1);
      for (int i = 0; i < 40; i++) step(0, 0, 2'b00, 1);

      // Clear with six words queued; time restarts at zero.
      for (int i = 0; i < 6; i++) step(1, 0, 2'b01, 0);
      step(1, 0, 2'b00, 0);
      step(1, 1, 2'b00, 0);
      @(posedge clk); #1;
      chk("clr_level", fifo_level, 0);
      chk("clr_drop_cnt", drop_cnt, 0);
      chk("clr_ev_valid", ev_valid, 0);
      step(1, 0, 2'b10, 1);
      step(1, 0, 2'b00, 1);
      @(posedge clk); #1;
      chk("clr_ts_restart", ev_data, 7'b0_0000_10);
      for (int i = 0; i < 3; i++) step(1, 0, 2'b00, 1);

      // Asynchronous reset with six words queued.
      for (int i = 0; i < 6; i++) step(1, 0, 2'b11, 0);
      step(0, 0, 2'b00, 0, 1);
      for (int i = 0; i < 8; i++) step(1, 0, N_CH'($urandom), 1);
      for (int i = 0; i < 10; i++) step(0, 0, 2'b00, 1);
      #3;
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spike_aer_logger.md
Name: spike_aer_logger

Overview:
- Hardware consumer for the output side of snn_simple: samples a vector of neuron spike lines each cycle and records every non-empty spike cycle as a timestamped address-event (AER) word in an internal FIFO.
- The FIFO is drained over a valid/ready stream, for example by a host bridge or trace DMA.
- It replaces bench-side CSV logging with an on-chip spike recorder that counts drops and keeps timestamps unambiguous across counter wrap.

Parameters:
- N_CH, 2, number of spike input channels; bit i of the mask is neuron i.
- TS_W, 16, width of the free-running cycle timestamp.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- EV_W, 1+TS_W+N_CH, event word width; derived, not to be overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  logging enable. When 0, the timestamp holds and spikes are ignored.
- clr  in  1  synchronous clear. Zeroes the timestamp, flushes the FIFO, clears drop_cnt and overflow.
- spk_in  in  N_CH  spike lines, one-cycle pulses, e.g. {n1_spike,n0_spike}.
- ev_valid  out  1  FIFO head is valid.
- ev_ready  in  1  consumer accepts the head.
- ev_data  out  EV_W  event word = {wrap, ts[TS_W-1:0], mask[N_CH-1:0]}.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  16  events lost to a full FIFO; saturates at 16'hFFFF.
- overflow  out  1  sticky flag; set on the first drop.

Behaviour:
- Reset (async, rst_n=0): ts=0, FIFO empty, ev_valid=0, ev_data=0, fifo_level=0, drop_cnt=0, overflow=0, started=0.
- Reset mid-operation discards all stored events immediately. No partial word is presented.
- Timestamp: ts increments by 1 on each clk edge where en=1 and clr=0. It wraps from 2^TS_W-1 to 0.
- started: set after the first increment. A wrap cycle is a cycle with en=1, ts==0 and started=1.
- Event generation, evaluated on each edge where en=1 and clr=0:
  - spike cycle (mask=spk_in != 0) -> push {wrap_cycle, ts, spk_in}.
  - wrap cycle with no spikes -> push marker {1, 0, 0}.
  - otherwise nothing is pushed.
  - At most one push per cycle. Simultaneous spikes on several channels share one word.
  - Every wrap yields exactly one word carrying wrap=1, unless that word is dropped.
- Full FIFO:
  - If a push is attempted while full and no pop occurs the same cycle, the word is dropped.
  - On a drop, drop_cnt increments (saturating) and overflow is set.
  - Simultaneous push and pop when full succeeds; level is unchanged.
- Read handshake:
  - A pop occurs on an edge where ev_valid&&ev_ready.
  - ev_data is stable and ev_valid stays high until popped. ev_valid never depends combinationally on ev_ready.
- Latency:
  - A spike sampled at edge k appears with ev_valid=1 after edge k+1 when the FIFO is empty.
  - A pop at edge k presents the next word after edge k.
- Push and pop in the same cycle when empty: the pushed word becomes valid next cycle and the pop is ignored.
- clr has priority over everything including push and pop. The clear takes effect at that edge, and drop_cnt and overflow are cleared with it.
- en=0:
  - No pushes, and ts and started freeze.
  - Reads continue and clr still acts.
- fifo_level reflects the registered occupancy after each edge. It ranges 0..DEPTH.

Decomposition:
- Add to lif_pkg.vh:
  - `AER_TS_W default.
  - Field offset macros: `AER_MASK_LSB=0, `AER_TS_LSB=N_CH, `AER_WRAP_BIT=EV_W-1.
  - `DROP_W=16.
- Sub-module aer_sync_fifo (parameters WIDTH, DEPTH):
  - Registered storage with pointer-wrap full/empty, level output, and first-word-fall-through head register.
- The top holds the timestamp counter, wrap/started logic, event builder, drop counter and overflow flag.

Test Plan:
- Single spike: after reset, 5 idle cycles, then spk_in=2'b01 for one cycle at ts=5, with ev_ready=1 -> one word {0,16'd5,2'b01}. ev_valid is high exactly one cycle, asserted at edge k+1.
- Simultaneous spikes: spk_in=2'b11 at ts=7 -> a single word {0,7,2'b11}. fifo_level peaks at 1.
- Wrap, using TS_W=4 and no spikes for 40 cycles -> markers {1,0,0} appear at cycles 16 and 32, and nothing else. A spike forced at the ts==0 wrap cycle -> {1,0,mask} and no separate marker.
- Overflow, DEPTH=16, ev_ready=0, spk_in=2'b01 for 20 cycles -> fifo_level=16, drop_cnt=4, overflow=1. Draining then yields ts 0..15 in order. A push+pop while full keeps level at 16 with no drop.
- Backpressure: toggle ev_ready pseudo-randomly during a random spike train; a scoreboard confirms all words arrive in order, unmodified, and ev_data is stable while ev_valid&&!ev_ready.
- Clear and reset mid-stream: with 6 words queued, pulse clr -> level=0, drop_cnt=0, ts restarts at 0. Repeat with rst_n low for 1ns asynchronously -> all outputs are 0 before the next clk edge.
